// File: rtl/tile_line_renderer_pkg.sv
// Shared definitions for the tile line renderer:
// FSM encoding and pattern-word geometry helpers.
package tile_line_renderer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } rendState_e;

    function automatic bit bppLegal(input int bpp);
        return bpp == 1 || bpp == 2 || bpp == 4 || bpp == 8;
    endfunction

    // log2 of the number of pixels packed in one 8-bit pattern word
    function automatic int pixFieldW(input int bpp);
        return (bpp == 1) ? 3 :
               (bpp == 2) ? 2 :
               (bpp == 4) ? 1 : 0;
    endfunction

    function automatic int wselW(input int tileLog2, input int bpp);
        int w;
        w = tileLog2 - pixFieldW(bpp);
        return (w > 0) ? w : 0;
    endfunction

endpackage

// File: rtl/tile_line_renderer_if.sv
// Line request handshake between the line sequencer
// and the tile line renderer, with per-line settings.
interface tile_line_renderer_if #(
    parameter int COORD_W = 9,
    parameter int COLOR_W = 15
);
    logic               start;
    logic               abort;
    logic [COORD_W-1:0] line_y;
    logic               bank;
    logic [COORD_W-1:0] scroll_x;
    logic [COORD_W-1:0] scroll_y;
    logic [COLOR_W-1:0] bg_color;
    logic               layer_en;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, line_y, bank,
        output scroll_x, scroll_y, bg_color, layer_en,
        input  busy, done
    );

    modport slave (
        input  start, abort, line_y, bank,
        input  scroll_x, scroll_y, bg_color, layer_en,
        output busy, done
    );
endinterface

// File: rtl/tile_line_renderer_pixel_pipe.sv
// Three-stage valid/x/column/tile shift pipeline that
// follows each pixel through the map, pattern and palette reads.
module tile_line_renderer_pixel_pipe #(
    parameter int XW         = 9,
    parameter int COORD_W    = 9,
    parameter int TILE_LOG2  = 3,
    parameter int TILE_IDX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   issue,
    input  logic [XW-1:0]          issueX,
    input  logic [COORD_W-1:0]     issueXs,
    input  logic [TILE_IDX_W-1:0]  tileIn,
    output logic                   s0Valid,
    output logic [COORD_W-TILE_LOG2-1:0] s0TileX,
    output logic                   s1Valid,
    output logic [TILE_LOG2-1:0]   s1Col,
    output logic                   s2Valid,
    output logic [TILE_LOG2-1:0]   s2Col,
    output logic [TILE_IDX_W-1:0]  s2Tile,
    output logic                   s3Valid,
    output logic [XW-1:0]          s3X
);
    logic [XW-1:0]      s0X;
    logic [XW-1:0]      s1X;
    logic [XW-1:0]      s2X;
    logic [COORD_W-1:0] s0Xs;

    assign s0TileX = s0Xs[COORD_W-1:TILE_LOG2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0Valid <= 1'b0;
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
            s3Valid <= 1'b0;
            s0X     <= '0;
            s0Xs    <= '0;
            s1X     <= '0;
            s1Col   <= '0;
            s2X     <= '0;
            s2Col   <= '0;
            s2Tile  <= '0;
            s3X     <= '0;
        end else begin
            if (flush) begin
                s0Valid <= 1'b0;
                s1Valid <= 1'b0;
                s2Valid <= 1'b0;
                s3Valid <= 1'b0;
            end else begin
                s0Valid <= issue;
                s1Valid <= s0Valid;
                s2Valid <= s1Valid;
                s3Valid <= s2Valid;
            end
            if (issue) begin
                s0X  <= issueX;
                s0Xs <= issueXs;
            end
            s1X    <= s0X;
            s1Col  <= s0Xs[TILE_LOG2-1:0];
            s2X    <= s1X;
            s2Col  <= s1Col;
            // map RAM answers during stage 1
            s2Tile <= tileIn;
            s3X    <= s2X;
        end
    end
endmodule

// File: rtl/tile_line_renderer.sv
// Renders one scanline of a scrolled tilemap layer into
// a line buffer: map -> pattern -> palette, then transparency.
module tile_line_renderer
    import tile_line_renderer_pkg::*;
#(
    parameter int LINE_W     = 400,
    parameter int LB_AW      = 10,
    parameter int MAP_LOG2   = 6,
    parameter int TILE_LOG2  = 3,
    parameter int BPP        = 2,
    parameter int TILE_IDX_W = 8,
    parameter int COLOR_W    = 15,
    localparam int WSEL_W    = wselW(TILE_LOG2, BPP),
    localparam int PAT_AW    = TILE_IDX_W + TILE_LOG2 + WSEL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    tile_line_renderer_if.slave       ctl,
    output logic [2*MAP_LOG2-1:0]     map_addr,
    input  logic [TILE_IDX_W-1:0]     map_data,
    output logic [PAT_AW-1:0]         pat_addr,
    input  logic [7:0]                pat_data,
    output logic [TILE_IDX_W+BPP-1:0] pal_addr,
    input  logic [COLOR_W:0]          pal_data,
    output logic                      lb_we,
    output logic [LB_AW-1:0]          lb_addr,
    output logic [COLOR_W-1:0]        lb_data
);
    localparam int COORD_W = MAP_LOG2 + TILE_LOG2;
    localparam int XW      = LB_AW - 1;
    localparam int PIX_W   = pixFieldW(BPP);
    localparam int PPW     = 8 / BPP;

    if (!bppLegal(BPP)) begin : gBadBpp
        $error("tile_line_renderer: BPP must be 1, 2, 4 or 8");
    end

    rendState_e         state;
    logic [XW-1:0]      xCnt;
    logic [COORD_W-1:0] scrollXL;
    logic [COORD_W-1:0] ysL;
    logic [COLOR_W-1:0] bgColorL;
    logic               bankL;
    logic               layerEnL;
    logic               busyQ;
    logic               doneQ;

    logic               startOk;
    logic               issue;
    logic [XW-1:0]      issueX;
    logic [COORD_W-1:0] issueXs;
    logic               lastWrite;

    logic                          s0Valid;
    logic [COORD_W-TILE_LOG2-1:0]  s0TileX;
    logic                          s1Valid;
    logic [TILE_LOG2-1:0]          s1Col;
    logic                          s2Valid;
    logic [TILE_LOG2-1:0]          s2Col;
    logic [TILE_IDX_W-1:0]         s2Tile;
    logic                          s3Valid;
    logic [XW-1:0]                 s3X;
    logic [BPP-1:0]                pixIdx;

    assign startOk = (state == ST_IDLE) && ctl.start && !ctl.abort;

    // pixel 0 issues on the start edge straight from the inputs
    always_comb begin
        issue   = 1'b0;
        issueX  = xCnt;
        issueXs = COORD_W'(xCnt) + scrollXL;
        if (startOk) begin
            issue   = 1'b1;
            issueX  = '0;
            issueXs = ctl.scroll_x;
        end else if (state == ST_RUN) begin
            issue = 1'b1;
        end
    end

    assign lastWrite = s3Valid && (s3X == XW'(LINE_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            xCnt     <= '0;
            scrollXL <= '0;
            ysL      <= '0;
            bgColorL <= '0;
            bankL    <= 1'b0;
            layerEnL <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else if (ctl.abort) begin
            state <= ST_IDLE;
            busyQ <= 1'b0;
            doneQ <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        state    <= (LINE_W == 1) ? ST_DRAIN : ST_RUN;
                        xCnt     <= XW'(1);
                        scrollXL <= ctl.scroll_x;
                        ysL      <= ctl.line_y + ctl.scroll_y;
                        bgColorL <= ctl.bg_color;
                        bankL    <= ctl.bank;
                        layerEnL <= ctl.layer_en;
                        busyQ    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    xCnt <= xCnt + XW'(1);
                    if (xCnt == XW'(LINE_W - 1)) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (lastWrite) begin
                        state <= ST_DONE;
                        busyQ <= 1'b0;
                        doneQ <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    tile_line_renderer_pixel_pipe #(
        .XW         (XW),
        .COORD_W    (COORD_W),
        .TILE_LOG2  (TILE_LOG2),
        .TILE_IDX_W (TILE_IDX_W)
    ) uPipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (ctl.abort),
        .issue   (issue),
        .issueX  (issueX),
        .issueXs (issueXs),
        .tileIn  (map_data),
        .s0Valid (s0Valid),
        .s0TileX (s0TileX),
        .s1Valid (s1Valid),
        .s1Col   (s1Col),
        .s2Valid (s2Valid),
        .s2Col   (s2Col),
        .s2Tile  (s2Tile),
        .s3Valid (s3Valid),
        .s3X     (s3X)
    );

    // leftmost pixel sits in the most significant field
    assign pixIdx = BPP'(pat_data >>
        ((PPW - 1 - (int'(s2Col) % PPW)) * BPP));

    assign map_addr = (s0Valid && layerEnL)
        ? {ysL[COORD_W-1:TILE_LOG2], s0TileX} : '0;

    assign pat_addr = (s1Valid && layerEnL)
        ? ((PAT_AW'({map_data, ysL[TILE_LOG2-1:0]}) << WSEL_W)
           | PAT_AW'(s1Col >> PIX_W))
        : '0;

    assign pal_addr = (s2Valid && layerEnL)
        ? {s2Tile, pixIdx} : '0;

    assign lb_we   = s3Valid;
    assign lb_addr = s3Valid ? {bankL, s3X} : '0;
    assign lb_data = (layerEnL && !pal_data[COLOR_W])
        ? pal_data[COLOR_W-1:0] : bgColorL;

    assign ctl.busy = busyQ;
    assign ctl.done = doneQ;
endmodule

// File: tb/tb_tile_line_renderer.sv
// Bench for tile_line_renderer: directed and random lines
// checked against a behavioural tilemap model.
module tb_tile_line_renderer;
    localparam int LINE_W  = 16;
    localparam int LB_AW   = 10;
    localparam int COORD_W = 9;
    localparam int WRAP    = 512;
    localparam logic [7:0] TILE_A = 8'h3A;
    localparam logic [7:0] TILE_B = 8'hC5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_line_renderer_if #(.COORD_W(COORD_W), .COLOR_W(15)) ctl();

    logic [11:0] map_addr;
    logic [7:0]  map_data;
    logic [11:0] pat_addr;
    logic [7:0]  pat_data;
    logic [9:0]  pal_addr;
    logic [15:0] pal_data;
    logic        lb_we;
    logic [9:0]  lb_addr;
    logic [14:0] lb_data;

    tile_line_renderer #(
        .LINE_W (LINE_W),
        .LB_AW  (LB_AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ctl      (ctl),
        .map_addr (map_addr),
        .map_data (map_data),
        .pat_addr (pat_addr),
        .pat_data (pat_data),
        .pal_addr (pal_addr),
        .pal_data (pal_data),
        .lb_we    (lb_we),
        .lb_addr  (lb_addr),
        .lb_data  (lb_data)
    );

    logic [7:0]  mapMem [4096];
    logic [7:0]  patMem [4096];
    logic [15:0] palMem [1024];

    always @(posedge clk) begin
        map_data <= mapMem[map_addr];
        pat_data <= patMem[pat_addr];
        pal_data <= palMem[pal_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [11:0] eMap [LINE_W];
    logic [11:0] ePat [LINE_W];
    logic [9:0]  ePal [LINE_W];
    logic [14:0] eCol [LINE_W];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic buildModel(input int ly, input int sx, input int sy,
                              input logic en, input logic [14:0] bg);
        for (int x = 0; x < LINE_W; x++) begin
            int xs, ys, tile, r, c, word, pix;
            logic [15:0] pal;
            xs = (x + sx) % WRAP;
            ys = (ly + sy) % WRAP;
            eMap[x] = 12'((ys / 8) * 64 + xs / 8);
            tile = int'(mapMem[eMap[x]]);
            r = ys % 8;
            c = xs % 8;
            ePat[x] = 12'(tile * 16 + r * 2 + c / 4);
            word = int'(patMem[ePat[x]]);
            pix = (word >> (6 - 2 * (c % 4))) & 3;
            ePal[x] = 10'(tile * 4 + pix);
            pal = palMem[ePal[x]];
            eCol[x] = (!en || pal[15]) ? bg : pal[14:0];
        end
    endtask

    task automatic runLine(input int ly, input int sx, input int sy,
                           input logic bk, input logic [14:0] bg,
                           input logic en, input int abortAt,
                           input int restartAt, input string tag);
        logic [11:0] map0, pat0;
        logic [9:0]  pal0;
        int last;
        bit live;
        buildModel(ly, sx, sy, en, bg);
        @(negedge clk);
        map0 = map_addr;
        pat0 = pat_addr;
        pal0 = pal_addr;
        ctl.line_y   = 9'(ly);
        ctl.scroll_x = 9'(sx);
        ctl.scroll_y = 9'(sy);
        ctl.bank     = bk;
        ctl.bg_color = bg;
        ctl.layer_en = en;
        ctl.start    = 1'b1;
        @(posedge clk);
        last = (abortAt > 0) ? abortAt : 1000;
        for (int k = 1; k <= LINE_W + 6; k++) begin
            @(negedge clk);
            cyc = k;
            live = (k <= last);
            check({tag, "/busy"}, 32'(ctl.busy),
                  32'(live && k <= LINE_W + 3));
            check({tag, "/done"}, 32'(ctl.done),
                  32'(live && k == LINE_W + 4));
            check({tag, "/we"}, 32'(lb_we),
                  32'(live && k >= 4 && k <= LINE_W + 3));
            if (live && k >= 4 && k <= LINE_W + 3) begin
                check({tag, "/lbaddr"}, 32'(lb_addr),
                      32'(int'(bk) * 512 + (k - 4)));
                check({tag, "/lbdata"}, 32'(lb_data), 32'(eCol[k-4]));
            end
            if (en) begin
                if (live && k <= LINE_W)
                    check({tag, "/map"}, 32'(map_addr), 32'(eMap[k-1]));
                if (live && k >= 2 && k <= LINE_W + 1)
                    check({tag, "/pat"}, 32'(pat_addr), 32'(ePat[k-2]));
                if (live && k >= 3 && k <= LINE_W + 2)
                    check({tag, "/pal"}, 32'(pal_addr), 32'(ePal[k-3]));
            end else begin
                check({tag, "/map_hold"}, 32'(map_addr), 32'(map0));
                check({tag, "/pat_hold"}, 32'(pat_addr), 32'(pat0));
                check({tag, "/pal_hold"}, 32'(pal_addr), 32'(pal0));
            end
            if (k == 1) begin
                ctl.line_y   = 9'($urandom);
                ctl.scroll_x = 9'($urandom);
                ctl.scroll_y = 9'($urandom);
                ctl.bank     = 1'($urandom);
                ctl.bg_color = 15'($urandom);
                ctl.layer_en = 1'($urandom);
            end
            ctl.start = (k == restartAt);
            if (k == restartAt) ctl.scroll_x = 9'(sx + 37);
            ctl.abort = (k == abortAt);
        end
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
    endtask

    initial begin
        ctl.start    = 1'b0;
        ctl.abort    = 1'b0;
        ctl.line_y   = '0;
        ctl.bank     = 1'b0;
        ctl.scroll_x = '0;
        ctl.scroll_y = '0;
        ctl.bg_color = '0;
        ctl.layer_en = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            mapMem[i] = (((i % 64) ^ (i / 64)) & 1) != 0 ? TILE_A : TILE_B;
            patMem[i] = 8'($urandom);
        end
        for (int i = 0; i < 1024; i++)
            palMem[i] = {1'b0, 15'($urandom)};

        // reset state
        repeat (3) @(negedge clk);
        check("rst/busy", 32'(ctl.busy), 0);
        check("rst/done", 32'(ctl.done), 0);
        check("rst/we", 32'(lb_we), 0);
        check("rst/map", 32'(map_addr), 0);
        check("rst/pat", 32'(pat_addr), 0);
        check("rst/pal", 32'(pal_addr), 0);
        check("rst/lbaddr", 32'(lb_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of a line
        ctl.line_y = 9'd3;
        ctl.start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            cyc = k;
            ctl.start = 1'b0;
            if (k == 6) begin
                check("t1/busy_pre", 32'(ctl.busy), 1);
                check("t1/we_pre", 32'(lb_we), 1);
            end
        end
        rst = 1'b1;
        #1;
        check("t1/busy_rst", 32'(ctl.busy), 0);
        check("t1/we_rst", 32'(lb_we), 0);
        check("t1/done_rst", 32'(ctl.done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runLine(5, 0, 0, 1'b0, 15'h1234, 1'b1, 0, 0, "t1_after");
        runLine(0, 0, 0, 1'b0, 15'h0ABC, 1'b1, 0, 0, "t2");
        runLine(1, WRAP - 3, 511, 1'b0, 15'h7001, 1'b1, 0, 0, "t3");

        palMem[int'(TILE_A) * 4][15] = 1'b1;
        palMem[int'(TILE_B) * 4][15] = 1'b1;
        runLine(6, 4, 9, 1'b0, 15'h19DD, 1'b1, 0, 0, "t4");

        runLine(20, 100, 7, 1'b0, 15'h0F0F, 1'b1, 9, 5, "t5");

        // start and abort together: abort wins
        @(negedge clk);
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        @(negedge clk);
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        cyc = 1;
        check("sa/busy", 32'(ctl.busy), 0);
        repeat (4) @(negedge clk);
        check("sa/we", 32'(lb_we), 0);
        check("sa/done", 32'(ctl.done), 0);

        runLine(33, 250, 61, 1'b1, 15'h2B6E, 1'b0, 0, 0, "t6");

        for (int n = 0; n < 6; n++) begin
            runLine(int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 511)),
                    int'($urandom_range(0, 511)),
                    1'($urandom), 15'($urandom),
                    ($urandom_range(0, 3) != 0), 0, 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
